max_pool_ctrl: RTL and testbench
================================

MAX_POOL_CTRL -- requirements
Module: max_pool_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 8, meaning input frame width in pixels (even, >=2).
REQ-002 SHALL have parameter IMG_H, default 8, meaning input frame height in rows (even, >=2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a frame.
REQ-006 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-007 SHALL have port in_valid, input, 1, input pixel valid.
REQ-008 SHALL have port in_pixel, input, 8, input pixel in raster order.
REQ-009 SHALL have port in_ready, output, 1, controller accepts in_pixel this cycle.
REQ-010 SHALL have port out_valid, output, 1, pooled pixel valid.
REQ-011 SHALL have port out_pixel, output, 8, max of one 2x2 block.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts out_pixel.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse at end of frame.

Function
REQ-014 SHALL implement states IDLE, EVEN_ROW, ODD_ROW, DONE.
REQ-015 IDLE: start=1 -> EVEN_ROW, column and row counters cleared; start ignored in every other state.
REQ-016 in_ready SHALL be 1 only in EVEN_ROW/ODD_ROW and only when NOT (out_valid=1 and out_ready=0); accept = in_valid & in_ready.
REQ-017 EVEN_ROW: each accepted pixel SHALL be written to an IMG_W x 8 line buffer at the current column.
REQ-018 ODD_ROW, even column: accepted pixel SHALL be held in a hold register.
REQ-019 ODD_ROW, odd column c: SHALL compute unsigned max of buf[c-1], buf[c], hold, in_pixel via an internal 2x2 max comparator tree; result registered into out_pixel, out_valid=1 the next cycle (latency 1 cycle from accepting the block's last pixel).
REQ-020 Ties SHALL yield the common maximum value; comparison is unsigned 8-bit, no width growth.
REQ-021 out_valid SHALL stay high with out_pixel stable until out_valid & out_ready; it then clears unless a new result is loaded that same cycle.
REQ-022 Column counter SHALL wrap to 0 after IMG_W-1 and advance the row; row wrap toggles EVEN_ROW <-> ODD_ROW.
REQ-023 Accepting pixel (IMG_W-1, IMG_H-1) SHALL move to DONE; DONE SHALL last exactly one cycle with frame_done=1, then go to IDLE.
REQ-024 busy SHALL be 1 in EVEN_ROW, ODD_ROW, DONE; 0 in IDLE.
REQ-025 A pending out_valid from the last block SHALL persist through DONE/IDLE until accepted; start in IDLE with out_valid pending SHALL still begin the frame (in_ready gated by REQ-016).
REQ-026 Frame SHALL produce exactly (IMG_W/2)*(IMG_H/2) outputs.

Reset
REQ-027 rst=1 SHALL asynchronously force: state IDLE, counters 0, hold 0, out_valid 0, out_pixel 0, frame_done 0, busy 0, in_ready 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; line buffer contents are not reset and are not observable.

Configuration
REQ-029 Macro MAX_POOL_STATS_EN defined: SHALL add output pool_count, 16 bits, incrementing on each out_valid & out_ready, cleared by rst and by start accepted in IDLE, saturating at 16'hFFFF.
REQ-030 Macro undefined: pool_count port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 IMG_W=4, IMG_H=2, out_ready=1, pixels 1..8 -> outputs 6 then 8, frame_done one cycle after pixel 8 accepted.
REQ-032 Frame of all 8'hFF except one 8'h00 per block -> every output 8'hFF; all-equal 8'h5A frame -> every output 8'h5A.
REQ-033 out_ready=0 when first result appears -> out_pixel held, in_ready=0 until out_ready=1, no output lost or duplicated.
REQ-034 rst pulse after 5 pixels accepted -> state IDLE, out_valid=0; new start plus full frame -> correct outputs.
REQ-035 start asserted mid-frame and in_valid asserted in IDLE -> no effect; output count stays (IMG_W/2)*(IMG_H/2).
REQ-036 With MAX_POOL_STATS_EN, default 8x8 frame -> pool_count=16 after frame; next start clears it to 0.

Source files
------------

// File: rtl/max_pool_ctrl.sv
// 2x2 max-pool controller: raster pixels in, one max per 2x2 block out.
// Optional MAX_POOL_STATS_EN adds a saturating pool_count output.
module max_pool_ctrl #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    input  logic        in_valid,
    input  logic [7:0]  in_pixel,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_pixel,
    input  logic        out_ready,
    output logic        frame_done
`ifdef MAX_POOL_STATS_EN
    ,
    output logic [15:0] pool_count
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {
        IDLE,
        EVEN_ROW,
        ODD_ROW,
        DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    logic [7:0]      hold_q;
    logic            out_valid_q;
    logic [7:0]      out_pixel_q;
    logic [7:0]      lb_q [IMG_W];

    logic            in_frame;
    logic            in_ready_d;
    logic            accept;
    logic            col_last;
    logic            row_last;
    logic            load_d;
    logic [CW-1:0]   pair_idx;
    logic [7:0]      max_top;
    logic [7:0]      max_bot;
    logic [7:0]      max_d;

    function automatic logic [7:0] max2(input logic [7:0] a,
                                        input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    // Handshake decode and the 2x2 comparator tree for the current block
    always_comb begin
        in_frame   = (state_q == EVEN_ROW) || (state_q == ODD_ROW);
        in_ready_d = in_frame && !(out_valid_q && !out_ready);
        accept     = in_valid && in_ready_d;
        col_last   = (col_q == CW'(IMG_W - 1));
        row_last   = (row_q == RW'(IMG_H - 1));
        load_d     = accept && (state_q == ODD_ROW) && col_q[0];
        pair_idx   = col_q ^ CW'(1);
        max_top    = max2(lb_q[pair_idx], lb_q[col_q]);
        max_bot    = max2(hold_q, in_pixel);
        max_d      = max2(max_top, max_bot);
    end

    // Frame FSM with raster counters, hold register and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
        end else begin
            if (load_d) begin
                out_valid_q <= 1'b1;
                out_pixel_q <= max_d;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= EVEN_ROW;
                        col_q   <= '0;
                        row_q   <= '0;
                    end
                end
                EVEN_ROW, ODD_ROW: begin
                    if (accept) begin
                        if (state_q == ODD_ROW && !col_q[0])
                            hold_q <= in_pixel;
                        if (col_last) begin
                            col_q <= '0;
                            if (row_last) begin
                                row_q   <= '0;
                                state_q <= DONE;
                            end else begin
                                row_q   <= row_q + 1'b1;
                                state_q <= (state_q == EVEN_ROW) ?
                                           ODD_ROW : EVEN_ROW;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line buffer holds the even row; contents are never reset
    always_ff @(posedge clk) begin
        if (accept && state_q == EVEN_ROW)
            lb_q[col_q] <= in_pixel;
    end

`ifdef MAX_POOL_STATS_EN
    logic [15:0] cnt_q;

    // Count delivered outputs, saturating, cleared when a frame starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (state_q == IDLE && start)
            cnt_q <= '0;
        else if (out_valid_q && out_ready && cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
    end

    assign pool_count = cnt_q;
`endif

    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign in_ready   = in_ready_d;
    assign out_valid  = out_valid_q;
    assign out_pixel  = out_pixel_q;

endmodule

// File: tb/tb_max_pool_ctrl.sv
// Scoreboard bench: a 4x2 and an 8x8 instance driven with random
// frames; expected block maxima are computed from whole-frame arrays.
module tb_max_pool_ctrl;

    logic       clk = 1'b0;
    logic       rst       [2];
    logic       start     [2];
    logic       busy      [2];
    logic       in_valid  [2];
    logic [7:0] in_pixel  [2];
    logic       in_ready  [2];
    logic       out_valid [2];
    logic [7:0] out_pixel [2];
    logic       out_ready [2];
    logic       frame_done[2];
`ifdef MAX_POOL_STATS_EN
    logic [15:0] pool_count [2];
`endif

    int errors = 0;
    int checks = 0;
    int ready_mode [2];
    int nout [2];
    int npush [2];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    bit   hold_v [2];
    logic [7:0] hold_p [2];

    always #5 clk = ~clk;

    max_pool_ctrl #(.IMG_W(4), .IMG_H(2)) dut0 (
        .clk       (clk),
        .rst       (rst[0]),
        .start     (start[0]),
        .busy      (busy[0]),
        .in_valid  (in_valid[0]),
        .in_pixel  (in_pixel[0]),
        .in_ready  (in_ready[0]),
        .out_valid (out_valid[0]),
        .out_pixel (out_pixel[0]),
        .out_ready (out_ready[0]),
        .frame_done(frame_done[0])
`ifdef MAX_POOL_STATS_EN
        ,
        .pool_count(pool_count[0])
`endif
    );

    max_pool_ctrl #(.IMG_W(8), .IMG_H(8)) dut1 (
        .clk       (clk),
        .rst       (rst[1]),
        .start     (start[1]),
        .busy      (busy[1]),
        .in_valid  (in_valid[1]),
        .in_pixel  (in_pixel[1]),
        .in_ready  (in_ready[1]),
        .out_valid (out_valid[1]),
        .out_pixel (out_pixel[1]),
        .out_ready (out_ready[1]),
        .frame_done(frame_done[1])
`ifdef MAX_POOL_STATS_EN
        ,
        .pool_count(pool_count[1])
`endif
    );

    function automatic int wd(int d);
        return (d == 0) ? 4 : 8;
    endfunction

    function automatic int ht(int d);
        return (d == 0) ? 2 : 8;
    endfunction

    function automatic void chk(bit ok, string nm, int act, int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic int qsize(int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void push(int d, logic [7:0] v);
        npush[d]++;
        if (d == 0) q0.push_back(v);
        else q1.push_back(v);
    endfunction

    function automatic logic [7:0] pop(int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Downstream ready: 0 always ready, 1 random, 2 held low
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            case (ready_mode[d])
                0:       out_ready[d] = 1'b1;
                1:       out_ready[d] = 1'($urandom % 2);
                default: out_ready[d] = 1'b0;
            endcase
        end
    end

    // Monitor: compares each delivered pixel against the scoreboard
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                hold_v[d] = 1'b0;
            end else if (out_valid[d]) begin
                if (hold_v[d])
                    chk(out_pixel[d] == hold_p[d], "hold_stable",
                        out_pixel[d], hold_p[d]);
                if (out_ready[d]) begin
                    if (qsize(d) == 0) begin
                        chk(1'b0, "extra_output", out_pixel[d], -1);
                    end else begin
                        logic [7:0] e;
                        e = pop(d);
                        chk(out_pixel[d] == e, "out_pixel",
                            out_pixel[d], e);
                    end
                    nout[d]++;
                    hold_v[d] = 1'b0;
                end else begin
                    chk(in_ready[d] == 1'b0, "stall_in_ready",
                        in_ready[d], 0);
                    hold_v[d] = 1'b1;
                    hold_p[d] = out_pixel[d];
                end
            end else begin
                if (hold_v[d])
                    chk(1'b0, "valid_dropped", 0, 1);
                hold_v[d] = 1'b0;
            end
        end
    end

    // Build a frame, queue its block maxima, and stream n pixels of it
    task automatic run_frame(int d, int kind, int n);
        logic [7:0] px [64];
        int w, h, np, i, tmo;
        bit acc;
        w  = wd(d);
        h  = ht(d);
        np = w * h;
        for (int k = 0; k < np; k++) begin
            case (kind)
                0:       px[k] = 8'(k + 1);
                1:       px[k] = 8'hFF;
                2:       px[k] = 8'h5A;
                default: px[k] = 8'($urandom);
            endcase
        end
        if (kind == 1) begin
            for (int br = 0; br < h / 2; br++)
                for (int bc = 0; bc < w / 2; bc++) begin
                    int r;
                    r = int'($urandom % 4);
                    px[(2 * br + r / 2) * w + 2 * bc + r % 2] = 8'h00;
                end
        end
        if (n == np) begin
            for (int br = 0; br < h / 2; br++)
                for (int bc = 0; bc < w / 2; bc++) begin
                    logic [7:0] m;
                    m = 8'h00;
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++)
                            if (px[(2 * br + dr) * w + 2 * bc + dc] > m)
                                m = px[(2 * br + dr) * w + 2 * bc + dc];
                    push(d, m);
                end
        end
        @(posedge clk);
        #1;
        in_valid[d] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_pixel[d] = 8'($urandom);
            @(negedge clk);
            chk(in_ready[d] == 1'b0, "idle_in_ready", in_ready[d], 0);
            @(posedge clk);
            #1;
        end
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d]    = 1'b0;
        in_valid[d] = 1'b0;
        @(negedge clk);
        chk(busy[d] == 1'b1, "busy_after_start", busy[d], 1);
`ifdef MAX_POOL_STATS_EN
        if (d == 1)
            chk(pool_count[1] == 16'd0, "stats_clear",
                pool_count[1], 0);
`endif
        @(posedge clk);
        #1;
        i   = 0;
        tmo = 0;
        while (i < n) begin
            in_valid[d] = ($urandom % 4 != 0);
            in_pixel[d] = px[i];
            start[d]    = ($urandom % 8 == 0);
            @(negedge clk);
            acc = in_valid[d] && in_ready[d];
            @(posedge clk);
            #1;
            if (acc) i++;
            tmo++;
            if (tmo > 5000) begin
                chk(1'b0, "accept_timeout", i, n);
                break;
            end
        end
        in_valid[d] = 1'b0;
        start[d]    = 1'b0;
        if (n == np && i == n) begin
            @(negedge clk);
            chk(frame_done[d] == 1'b1, "frame_done_hi", frame_done[d], 1);
            chk(busy[d] == 1'b1, "busy_in_done", busy[d], 1);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk(frame_done[d] == 1'b0, "frame_done_lo", frame_done[d], 0);
            chk(busy[d] == 1'b0, "busy_idle", busy[d], 0);
        end
    endtask

    task automatic drain(int d);
        int t;
        ready_mode[d] = 0;
        t = 0;
        while (qsize(d) != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        chk(qsize(d) == 0, "drain_empty", qsize(d), 0);
        chk(nout[d] == npush[d], "output_count", nout[d], npush[d]);
    endtask

    task automatic pulse_reset(int d);
        @(posedge clk);
        #1;
        rst[d] = 1'b1;
        @(negedge clk);
        chk(out_valid[d] == 1'b0, "rst_out_valid", out_valid[d], 0);
        chk(out_pixel[d] == 8'h00, "rst_out_pixel", out_pixel[d], 0);
        chk(busy[d] == 1'b0, "rst_busy", busy[d], 0);
        chk(in_ready[d] == 1'b0, "rst_in_ready", in_ready[d], 0);
        chk(frame_done[d] == 1'b0, "rst_frame_done", frame_done[d], 0);
        @(posedge clk);
        #1;
        rst[d] = 1'b0;
    endtask

    task automatic stats_check(int exp);
`ifdef MAX_POOL_STATS_EN
        chk(pool_count[1] == 16'(exp), "pool_count", pool_count[1], exp);
`else
        if (exp < 0) $display("unused %0d", exp);
`endif
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d]        = 1'b1;
            start[d]      = 1'b0;
            in_valid[d]   = 1'b0;
            in_pixel[d]   = 8'h00;
            out_ready[d]  = 1'b1;
            ready_mode[d] = 0;
            nout[d]       = 0;
            npush[d]      = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk(out_valid[d] == 1'b0, "init_out_valid", out_valid[d], 0);
            chk(busy[d] == 1'b0, "init_busy", busy[d], 0);
            chk(in_ready[d] == 1'b0, "init_in_ready", in_ready[d], 0);
            chk(frame_done[d] == 1'b0, "init_frame_done",
                frame_done[d], 0);
            chk(out_pixel[d] == 8'h00, "init_out_pixel", out_pixel[d], 0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        run_frame(0, 0, 8);
        drain(0);

        ready_mode[0] = 2;
        fork
            run_frame(0, 0, 8);
            begin
                repeat (30) @(posedge clk);
                @(negedge clk);
                chk(out_valid[0] && !in_ready[0], "stall_seen",
                    out_valid[0], 1);
                ready_mode[0] = 0;
            end
        join
        drain(0);

        ready_mode[0] = 1;
        for (int f = 0; f < 6; f++)
            run_frame(0, 1 + f % 3, 8);
        drain(0);

        run_frame(1, 0, 64);
        drain(1);
        stats_check(16);

        for (int k = 1; k < 4; k++) begin
            ready_mode[1] = 1;
            run_frame(1, k, 64);
            drain(1);
            stats_check(16);
        end

        run_frame(1, 3, 5);
        pulse_reset(1);
        stats_check(0);
        ready_mode[1] = 1;
        run_frame(1, 3, 64);
        drain(1);
        stats_check(16);

        run_frame(0, 3, 5);
        pulse_reset(0);
        ready_mode[0] = 1;
        run_frame(0, 0, 8);
        drain(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
